// File: rtl/icache_pkg.sv
// Shared types, default geometry and helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MEM_WAIT
    } state_e;

    localparam int ICACHE_ADDR_W      = 16;
    localparam int ICACHE_WORD_W      = 32;
    localparam int ICACHE_BLOCK_WORDS = 4;
    localparam int ICACHE_INDEX_W     = 3;
    localparam int ICACHE_OFF_W       = $clog2(ICACHE_BLOCK_WORDS);
    localparam int ICACHE_TAG_W       = ICACHE_ADDR_W - ICACHE_INDEX_W - ICACHE_OFF_W;

    // Generic field extract so the caller's geometry parameters stay in control.
    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        return (addr >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/inst_cache_tags.sv
// Tag/valid store: async-cleared valid bits, one-cycle flush, single write port, combinational hit.
module inst_cache_tags import icache_pkg::*; #(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = ICACHE_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] index_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               hit_o
);

    localparam int LINES = 1 << INDEX_W;

    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[index_i] <= 1'b1;
        end
    end

    // Tags are meaningless while their valid bit is clear, so they carry no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[index_i] <= tag_i;
        end
    end

    assign hit_o = valid_q[index_i] && (tag_q[index_i] == tag_i);

endmodule

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped instruction-cache controller: hit/miss FSM, DRAM block fill, SRAM control, counters.
module inst_cache_ctrl import icache_pkg::*; #(
    parameter int ADDR_W      = ICACHE_ADDR_W,
    parameter int WORD_W      = ICACHE_WORD_W,
    parameter int BLOCK_WORDS = ICACHE_BLOCK_WORDS,
    parameter int INDEX_W     = ICACHE_INDEX_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cpu_req,
    input  logic [ADDR_W-1:0]                   cpu_addr,
    input  logic                                flush,
    output logic                                cpu_ready,
    output logic [WORD_W-1:0]                   cpu_inst,
    output logic                                mem_req,
    output logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0] mem_addr,
    input  logic                                mem_ready,
    input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]  mem_data,
    output logic                                sram_we,
    output logic [INDEX_W-1:0]                  sram_index,
    output logic [BLOCK_WORDS-1:0][WORD_W-1:0]  sram_wdata,
    input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]  sram_rdata,
    output logic [31:0]                         hit_count,
    output logic [31:0]                         miss_count
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;

    state_e                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    cpu_ready_q;
    logic [WORD_W-1:0]       cpu_inst_q;
    logic                    mem_req_q;
    logic [ADDR_W-OFF_W-1:0] mem_addr_q;
    logic [31:0]             hit_cnt_q;
    logic [31:0]             miss_cnt_q;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [OFF_W-1:0]   req_off;
    logic               hit;
    logic               fill;

    assign req_tag   = TAG_W'(addr_field(32'(addr_q), OFF_W + INDEX_W, TAG_W));
    assign req_index = INDEX_W'(addr_field(32'(addr_q), OFF_W, INDEX_W));
    assign req_off   = OFF_W'(addr_field(32'(addr_q), 0, OFF_W));

    assign fill = (state_q == MEM_WAIT) && mem_ready;

    inst_cache_tags #(
        .INDEX_W(INDEX_W),
        .TAG_W  (TAG_W)
    ) u_tags (
        .clk    (clk),
        .rst    (rst),
        .flush_i(flush && (state_q == IDLE)),
        .we_i   (fill),
        .index_i(req_index),
        .tag_i  (req_tag),
        .hit_o  (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cpu_ready_q <= 1'b0;
            cpu_inst_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Flush wins over a simultaneous request; the request is simply dropped.
                    if (!flush && cpu_req) begin
                        addr_q  <= cpu_addr;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        cpu_inst_q  <= sram_rdata[req_off];
                        cpu_ready_q <= 1'b1;
                        hit_cnt_q   <= sat_inc(hit_cnt_q);
                        state_q     <= IDLE;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= addr_q[ADDR_W-1:OFF_W];
                        miss_cnt_q <= sat_inc(miss_cnt_q);
                        state_q    <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    // The refilled line is re-looked-up, so every miss also ends as a hit.
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= LOOKUP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ready  = cpu_ready_q;
    assign cpu_inst   = cpu_inst_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign sram_we    = fill;
    assign sram_index = req_index;
    assign sram_wdata = mem_data;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Directed bench for inst_cache_ctrl with a behavioural SRAM attached to the SRAM port.
module tb_inst_cache_ctrl;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic [15:0]       cpu_addr;
    logic              flush;
    logic              cpu_ready;
    logic [31:0]       cpu_inst;
    logic              mem_req;
    logic [13:0]       mem_addr;
    logic              mem_ready;
    logic [3:0][31:0]  mem_data;
    logic              sram_we;
    logic [2:0]        sram_index;
    logic [3:0][31:0]  sram_wdata;
    logic [3:0][31:0]  sram_rdata;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    logic [3:0][31:0]  sram_mem [8];

    int tests;
    int fails;

    inst_cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .flush     (flush),
        .cpu_ready (cpu_ready),
        .cpu_inst  (cpu_inst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .sram_we   (sram_we),
        .sram_index(sram_index),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_index] <= sram_wdata;
    end
    assign sram_rdata = sram_mem[sram_index];

    function automatic logic [3:0][31:0] mk_block(input logic [31:0] base);
        logic [3:0][31:0] b;
        for (int k = 0; k < 4; k++) b[k] = base + 32'(k);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one fetch, answering a miss after w cycles with blk; only observes, never judges.
    task automatic fetch(input logic [15:0] addr, input int w, input logic [3:0][31:0] blk,
                         output int lat, output logic missed, output logic [13:0] maddr,
                         output logic [31:0] inst, output int we_cnt, output logic [2:0] we_idx,
                         output logic req_after, output logic timed_out);
        int guard;
        lat = 0; missed = 1'b0; maddr = '0; inst = '0; we_cnt = 0; we_idx = '0;
        req_after = 1'b0; guard = 0;
        cpu_req = 1'b1;
        cpu_addr = addr;
        while (guard < 100) begin
            tick();
            lat++;
            guard++;
            if (cpu_ready) begin
                inst = cpu_inst;
                break;
            end
            if (sram_we) we_cnt++;
            if (mem_req && !missed) begin
                missed = 1'b1;
                maddr = mem_addr;
                for (int i = 1; i < w; i++) begin
                    tick();
                    guard++;
                    if (sram_we) we_cnt++;
                end
                mem_data = blk;
                mem_ready = 1'b1;
                #1;
                if (sram_we) we_cnt++;
                we_idx = sram_index;
                tick();
                mem_ready = 1'b0;
                req_after = mem_req;
                lat = 1;
            end
        end
        timed_out = !cpu_ready;
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL reset_cpu_ready got=%b exp=0", cpu_ready); end
        tests++; if (cpu_inst !== 32'h0) begin fails++; $display("FAIL reset_cpu_inst got=%h exp=0", cpu_inst); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        tests++; if (mem_addr !== 14'h0) begin fails++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        tests++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin fails++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
        tests++; if (sram_we !== 1'b0) begin fails++; $display("FAIL reset_sram_we got=%b exp=0", sram_we); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cold_miss();
        int lat; logic missed; logic [13:0] maddr; logic [31:0] inst; int we_cnt; logic [2:0] we_idx;
        logic req_after; logic to;
        fetch(16'h0045, 3, mk_block(32'hA000_0000), lat, missed, maddr, inst, we_cnt, we_idx, req_after, to);
        tests++; if (to !== 1'b0) begin fails++; $display("FAIL cold_timeout got=%b exp=0", to); end
        tests++; if (missed !== 1'b1) begin fails++; $display("FAIL cold_mem_req got=%b exp=1", missed); end
        tests++; if (maddr !== 14'h011) begin fails++; $display("FAIL cold_mem_addr got=%h exp=011", maddr); end
        tests++; if (we_cnt !== 1 || we_idx !== 3'd1) begin fails++; $display("FAIL cold_sram_we got=%0d@%0d exp=1@1", we_cnt, we_idx); end
        tests++; if (req_after !== 1'b0) begin fails++; $display("FAIL cold_mem_req_drop got=%b exp=0", req_after); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL cold_latency got=%0d exp=2", lat); end
        tests++; if (inst !== 32'hA000_0001) begin fails++; $display("FAIL cold_inst got=%h exp=a0000001", inst); end
        tests++; if (miss_count !== 32'd1 || hit_count !== 32'd1) begin fails++; $display("FAIL cold_counts got=%0d/%0d exp=1/1", miss_count, hit_count); end
        tick();
        tests++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL cold_ready_pulse got=%b exp=0", cpu_ready); end
    endtask

    task automatic test_hit();
        int lat; logic missed; logic [13:0] maddr; logic [31:0] inst; int we_cnt; logic [2:0] we_idx;
        logic req_after; logic to;
        fetch(16'h0047, 3, mk_block(32'hDEAD_0000), lat, missed, maddr, inst, we_cnt, we_idx, req_after, to);
        tests++; if (to !== 1'b0) begin fails++; $display("FAIL hit_timeout got=%b exp=0", to); end
        tests++; if (missed !== 1'b0) begin fails++; $display("FAIL hit_mem_req got=%b exp=0", missed); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL hit_latency got=%0d exp=2", lat); end
        tests++; if (inst !== 32'hA000_0003) begin fails++; $display("FAIL hit_inst got=%h exp=a0000003", inst); end
        tests++; if (hit_count !== 32'd2 || miss_count !== 32'd1) begin fails++; $display("FAIL hit_counts got=%0d/%0d exp=2/1", hit_count, miss_count); end
        tick();
    endtask

    task automatic test_conflict();
        int lat; logic missed; logic [13:0] maddr; logic [31:0] inst; int we_cnt; logic [2:0] we_idx;
        logic req_after; logic to;
        fetch(16'h0025, 2, mk_block(32'hB000_0000), lat, missed, maddr, inst, we_cnt, we_idx, req_after, to);
        tests++; if (missed !== 1'b1 || maddr !== 14'h009) begin fails++; $display("FAIL conflict_miss got=%b/%h exp=1/009", missed, maddr); end
        tests++; if (inst !== 32'hB000_0001 || to !== 1'b0) begin fails++; $display("FAIL conflict_inst got=%h exp=b0000001", inst); end
        tests++; if (miss_count !== 32'd2 || hit_count !== 32'd3) begin fails++; $display("FAIL conflict_counts got=%0d/%0d exp=2/3", miss_count, hit_count); end
        tick();
        fetch(16'h0045, 1, mk_block(32'hA000_0000), lat, missed, maddr, inst, we_cnt, we_idx, req_after, to);
        tests++; if (missed !== 1'b1 || maddr !== 14'h011) begin fails++; $display("FAIL refetch_miss got=%b/%h exp=1/011", missed, maddr); end
        tests++; if (inst !== 32'hA000_0001 || to !== 1'b0) begin fails++; $display("FAIL refetch_inst got=%h exp=a0000001", inst); end
        tests++; if (miss_count !== 32'd3 || hit_count !== 32'd4) begin fails++; $display("FAIL refetch_counts got=%0d/%0d exp=3/4", miss_count, hit_count); end
        tick();
    endtask

    task automatic test_flush();
        int lat; logic missed; logic [13:0] maddr; logic [31:0] inst; int we_cnt; logic [2:0] we_idx;
        logic req_after; logic to;
        flush = 1'b1;
        cpu_req = 1'b1;
        cpu_addr = 16'h0045;
        tick();
        flush = 1'b0;
        cpu_req = 1'b0;
        repeat (3) tick();
        tests++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin fails++; $display("FAIL flush_req_ignored got=%b/%b exp=0/0", mem_req, cpu_ready); end
        tests++; if (hit_count !== 32'd4 || miss_count !== 32'd3) begin fails++; $display("FAIL flush_counts got=%0d/%0d exp=4/3", hit_count, miss_count); end
        fetch(16'h0045, 2, mk_block(32'hA000_0000), lat, missed, maddr, inst, we_cnt, we_idx, req_after, to);
        tests++; if (missed !== 1'b1 || inst !== 32'hA000_0001) begin fails++; $display("FAIL flush_invalidates got=%b/%h exp=1/a0000001", missed, inst); end
        tick();
        fetch(16'h0025, 2, mk_block(32'hB000_0000), lat, missed, maddr, inst, we_cnt, we_idx, req_after, to);
        tests++; if (missed !== 1'b1 || maddr !== 14'h009) begin fails++; $display("FAIL flush_next_miss got=%b/%h exp=1/009", missed, maddr); end
        tests++; if (miss_count !== 32'd5 || hit_count !== 32'd6) begin fails++; $display("FAIL flush_final_counts got=%0d/%0d exp=5/6", miss_count, hit_count); end
        tick();
    endtask

    task automatic test_reset_in_mem_wait();
        cpu_req = 1'b1;
        cpu_addr = 16'h0010;
        tick();
        cpu_req = 1'b0;
        tick();
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rstwait_mem_req got=%b exp=1", mem_req); end
        rst = 1'b1;
        #1;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rstwait_async got=%b exp=0", mem_req); end
        #1;
        rst = 1'b0;
        mem_data = mk_block(32'hC000_0000);
        mem_ready = 1'b1;
        #1;
        tests++; if (sram_we !== 1'b0) begin fails++; $display("FAIL rstwait_sram_we got=%b exp=0", sram_we); end
        tick();
        mem_ready = 1'b0;
        tick();
        tests++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin fails++; $display("FAIL rstwait_idle got=%b/%b exp=0/0", mem_req, cpu_ready); end
        tests++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin fails++; $display("FAIL rstwait_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    endtask

    task automatic test_stray_mem_ready();
        int lat; logic missed; logic [13:0] maddr; logic [31:0] inst; int we_cnt; logic [2:0] we_idx;
        logic req_after; logic to;
        mem_data = mk_block(32'hEEEE_0000);
        mem_ready = 1'b1;
        #1;
        tests++; if (sram_we !== 1'b0) begin fails++; $display("FAIL stray_sram_we got=%b exp=0", sram_we); end
        tick();
        mem_ready = 1'b0;
        tick();
        fetch(16'h0010, 2, mk_block(32'hD000_0000), lat, missed, maddr, inst, we_cnt, we_idx, req_after, to);
        tests++; if (missed !== 1'b1 || maddr !== 14'h004) begin fails++; $display("FAIL stray_no_valid got=%b/%h exp=1/004", missed, maddr); end
        tests++; if (inst !== 32'hD000_0000 || to !== 1'b0) begin fails++; $display("FAIL stray_inst got=%h exp=d0000000", inst); end
        tests++; if (miss_count !== 32'd1 || hit_count !== 32'd1) begin fails++; $display("FAIL stray_counts got=%0d/%0d exp=1/1", miss_count, hit_count); end
        tick();
    endtask

    task automatic test_back_to_back();
        cpu_req = 1'b1;
        cpu_addr = 16'h0011;
        tick();
        tick();
        tests++; if (cpu_ready !== 1'b1 || cpu_inst !== 32'hD000_0001) begin fails++; $display("FAIL b2b_first got=%b/%h exp=1/d0000001", cpu_ready, cpu_inst); end
        cpu_addr = 16'h0013;
        tick();
        tests++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL b2b_gap got=%b exp=0", cpu_ready); end
        tick();
        cpu_req = 1'b0;
        tests++; if (cpu_ready !== 1'b1 || cpu_inst !== 32'hD000_0003) begin fails++; $display("FAIL b2b_second got=%b/%h exp=1/d0000003", cpu_ready, cpu_inst); end
        tests++; if (hit_count !== 32'd3 || miss_count !== 32'd1) begin fails++; $display("FAIL b2b_counts got=%0d/%0d exp=3/1", hit_count, miss_count); end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_addr = '0;
        flush = 1'b0;
        mem_ready = 1'b0;
        mem_data = '0;
        for (int i = 0; i < 8; i++) sram_mem[i] = '0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_reset_in_mem_wait();
        test_stray_mem_ready();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
